// File: rtl/hilo_muldiv_ctrl_if.sv
// rtl/hilo_muldiv_ctrl_if.sv - execute-stage request and HI/LO status bundle
interface hilo_muldiv_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        flush;
  logic        hilo_busy;
  logic [31:0] hi;
  logic [31:0] lo;

  // Execute stage side: offers operations, watches HI/LO status
  modport master (
    output req_valid,
    output req_op,
    output req_src1,
    output req_src2,
    output flush,
    input  req_ready,
    input  hilo_busy,
    input  hi,
    input  lo
  );

  // HI/LO owner side
  modport slave (
    input  req_valid,
    input  req_op,
    input  req_src1,
    input  req_src2,
    input  flush,
    output req_ready,
    output hilo_busy,
    output hi,
    output lo
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - HI/LO register owner with mult/div/mthi/mtlo scheduling
module hilo_muldiv_ctrl #(
  parameter int DIV_ITER = 32
) (
  input logic                 clk,
  input logic                 resetn,
  hilo_muldiv_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  // opa holds the multiplicand in MUL and the dividend/quotient shift register in DIV
  logic [31:0] opa;
  // opb holds the multiplier in MUL and the divisor magnitude in DIV
  logic [31:0] opb;
  logic [31:0] rem_q;
  logic        mul_signed;
  logic        neg_quot;
  logic        neg_rem;

  logic        accept;
  logic        div_signed;
  logic [31:0] abs_src1;
  logic [31:0] abs_src2;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;
  logic [32:0] rem_shift;
  logic [32:0] trial_diff;
  logic        take;
  logic [31:0] rem_next;
  logic [31:0] quot_next;
  logic [31:0] quot_final;
  logic [31:0] rem_final;

  assign bus.req_ready = (state == S_IDLE);
  assign bus.hilo_busy = (state == S_MUL) || (state == S_DIV);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

  // Flush beats accept so a dropped request never writes HI/LO
  assign accept     = bus.req_valid && (state == S_IDLE) && !bus.flush;
  assign div_signed = (bus.req_op == OP_DIV);

  // Magnitudes wrap in 32 bits, so 0x80000000 stays 0x80000000
  assign abs_src1 = (div_signed && bus.req_src1[31]) ? (32'd0 - bus.req_src1) : bus.req_src1;
  assign abs_src2 = (div_signed && bus.req_src2[31]) ? (32'd0 - bus.req_src2) : bus.req_src2;

  // Extending to 64 bits first makes the low 64 product bits correct for both signednesses
  assign mul_a   = mul_signed ? {{32{opa[31]}}, opa} : {32'd0, opa};
  assign mul_b   = mul_signed ? {{32{opb[31]}}, opb} : {32'd0, opb};
  assign product = mul_a * mul_b;

  // One restoring step: bit 32 of the trial difference is the borrow
  assign rem_shift  = {rem_q, opa[31]};
  assign trial_diff = rem_shift - {1'b0, opb};
  assign take       = !trial_diff[32];
  assign rem_next   = take ? trial_diff[31:0] : rem_shift[31:0];
  assign quot_next  = {opa[30:0], take};
  assign quot_final = neg_quot ? (32'd0 - quot_next) : quot_next;
  assign rem_final  = neg_rem ? (32'd0 - rem_next) : rem_next;

  // Control FSM plus HI/LO and operand registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= 6'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      opa        <= 32'd0;
      opb        <= 32'd0;
      rem_q      <= 32'd0;
      mul_signed <= 1'b0;
      neg_quot   <= 1'b0;
      neg_rem    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (bus.req_op)
              OP_MTHI: hi_q <= bus.req_src1;
              OP_MTLO: lo_q <= bus.req_src1;
              OP_MULT, OP_MULTU: begin
                opa        <= bus.req_src1;
                opb        <= bus.req_src2;
                mul_signed <= (bus.req_op == OP_MULT);
                state      <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                // Divide by zero leaves HI/LO untouched and never goes busy
                if (bus.req_src2 != 32'd0) begin
                  opa      <= abs_src1;
                  opb      <= abs_src2;
                  rem_q    <= 32'd0;
                  neg_quot <= div_signed && (bus.req_src1[31] ^ bus.req_src2[31]);
                  neg_rem  <= div_signed && bus.req_src1[31];
                  cnt      <= 6'(DIV_ITER);
                  state    <= S_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (!bus.flush) begin
            hi_q <= product[63:32];
            lo_q <= product[31:0];
          end
          state <= S_IDLE;
        end
        S_DIV: begin
          if (bus.flush) begin
            cnt   <= 6'd0;
            state <= S_IDLE;
          end else begin
            opa   <= quot_next;
            rem_q <= rem_next;
            cnt   <= cnt - 6'd1;
            if (cnt == 6'd1) begin
              lo_q  <= quot_final;
              hi_q  <= rem_final;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb/tb_hilo_muldiv_ctrl.sv - directed self-checking bench for hilo_muldiv_ctrl
module tb_hilo_muldiv_ctrl;
  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  hilo_muldiv_ctrl_if bus ();

  hilo_muldiv_ctrl #(.DIV_ITER(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle, landing 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one op for a single edge; returns in cycle T+1
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_src1  = a;
    bus.req_src2  = b;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    checks += 4;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", bus.req_ready); end
    if (bus.hilo_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.hilo_busy); end
    if (bus.hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    if (bus.lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", bus.lo); end
  endtask

  task automatic test_multu();
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checks += 2;
    if (bus.hilo_busy !== 1'b1) begin errors++; $display("FAIL multu_busy got %0b want 1", bus.hilo_busy); end
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL multu_ready_low got %0b want 0", bus.req_ready); end
    step();
    checks += 4;
    if (bus.hilo_busy !== 1'b0) begin errors++; $display("FAIL multu_busy_end got %0b want 0", bus.hilo_busy); end
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL multu_ready_back got %0b want 1", bus.req_ready); end
    if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", bus.hi); end
    if (bus.lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want 00000001", bus.lo); end
  endtask

  task automatic test_mult();
    issue(3'd0, 32'hFFFFFFFD, 32'd5);
    step();
    checks += 2;
    if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", bus.hi); end
    if (bus.lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo got %h want fffffff1", bus.lo); end
  endtask

  task automatic test_div_signed();
    int n;
    int ready_seen;
    n = 0;
    ready_seen = 0;
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    while (bus.hilo_busy === 1'b1 && n < 40) begin
      if (bus.req_ready !== 1'b0) ready_seen++;
      n++;
      step();
    end
    checks += 4;
    if (n != 32) begin errors++; $display("FAIL div_busy_cycles got %0d want 32", n); end
    if (ready_seen != 0) begin errors++; $display("FAIL div_ready_during_busy got %0d cycles want 0", ready_seen); end
    if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", bus.lo); end
    if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", bus.hi); end
  endtask

  task automatic test_divu();
    issue(3'd3, 32'd100, 32'd7);
    repeat (32) step();
    checks += 3;
    if (bus.hilo_busy !== 1'b0) begin errors++; $display("FAIL divu_busy_end got %0b want 0", bus.hilo_busy); end
    if (bus.lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %0d want 14", bus.lo); end
    if (bus.hi !== 32'd2) begin errors++; $display("FAIL divu_hi got %0d want 2", bus.hi); end
  endtask

  task automatic test_div_corner();
    int busy_seen;
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    repeat (32) step();
    checks += 2;
    if (bus.lo !== 32'h80000000) begin errors++; $display("FAIL div_min_lo got %h want 80000000", bus.lo); end
    if (bus.hi !== 32'h00000000) begin errors++; $display("FAIL div_min_hi got %h want 0", bus.hi); end
    issue(3'd4, 32'h00001234, 32'd0);
    issue(3'd5, 32'h0000ABCD, 32'd0);
    busy_seen = 0;
    issue(3'd3, 32'd77, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (bus.hilo_busy !== 1'b0) busy_seen++;
      step();
    end
    checks += 3;
    if (busy_seen != 0) begin errors++; $display("FAIL divzero_busy got %0d cycles want 0", busy_seen); end
    if (bus.hi !== 32'h00001234) begin errors++; $display("FAIL divzero_hi got %h want 00001234", bus.hi); end
    if (bus.lo !== 32'h0000ABCD) begin errors++; $display("FAIL divzero_lo got %h want 0000abcd", bus.lo); end
  endtask

  task automatic test_mthi_flush();
    issue(3'd5, 32'h00000077, 32'd0);
    issue(3'd4, 32'h000055AA, 32'd0);
    issue(3'd2, 32'd10, 32'd3);
    repeat (9) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks += 4;
    if (bus.hilo_busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %0b want 0", bus.hilo_busy); end
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b want 1", bus.req_ready); end
    if (bus.hi !== 32'h000055AA) begin errors++; $display("FAIL flush_hi got %h want 000055aa", bus.hi); end
    if (bus.lo !== 32'h00000077) begin errors++; $display("FAIL flush_lo got %h want 00000077", bus.lo); end
    issue(3'd0, 32'd2, 32'd3);
    checks += 1;
    if (bus.hilo_busy !== 1'b1) begin errors++; $display("FAIL postflush_mult_busy got %0b want 1", bus.hilo_busy); end
    step();
    checks += 2;
    if (bus.lo !== 32'd6) begin errors++; $display("FAIL postflush_mult_lo got %0d want 6", bus.lo); end
    if (bus.hi !== 32'd0) begin errors++; $display("FAIL postflush_mult_hi got %h want 0", bus.hi); end
  endtask

  task automatic test_flush_last_div();
    issue(3'd3, 32'd50, 32'd5);
    repeat (31) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks += 3;
    if (bus.hilo_busy !== 1'b0) begin errors++; $display("FAIL flush_last_busy got %0b want 0", bus.hilo_busy); end
    if (bus.lo !== 32'd6) begin errors++; $display("FAIL flush_last_lo got %0d want 6", bus.lo); end
    if (bus.hi !== 32'd0) begin errors++; $display("FAIL flush_last_hi got %h want 0", bus.hi); end
  endtask

  task automatic test_flush_idle();
    bus.flush = 1'b1;
    issue(3'd4, 32'hDEADBEEF, 32'd0);
    bus.flush = 1'b0;
    checks += 2;
    if (bus.hi !== 32'd0) begin errors++; $display("FAIL idle_flush_hi got %h want 0", bus.hi); end
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL idle_flush_ready got %0b want 1", bus.req_ready); end
  endtask

  task automatic test_back_to_back();
    issue(3'd4, 32'h00000011, 32'd0);
    checks += 2;
    if (bus.hi !== 32'h00000011) begin errors++; $display("FAIL b2b_mthi got %h want 00000011", bus.hi); end
    if (bus.hilo_busy !== 1'b0) begin errors++; $display("FAIL b2b_mthi_busy got %0b want 0", bus.hilo_busy); end
    issue(3'd5, 32'h00000022, 32'd0);
    checks += 2;
    if (bus.lo !== 32'h00000022) begin errors++; $display("FAIL b2b_mtlo got %h want 00000022", bus.lo); end
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_mtlo_ready got %0b want 1", bus.req_ready); end
    issue(3'd1, 32'd7, 32'd6);
    step();
    checks += 2;
    if (bus.hi !== 32'd0) begin errors++; $display("FAIL b2b_mult_hi got %h want 0", bus.hi); end
    if (bus.lo !== 32'd42) begin errors++; $display("FAIL b2b_mult_lo got %0d want 42", bus.lo); end
  endtask

  task automatic test_reset_mid_div();
    issue(3'd4, 32'h0000BEEF, 32'd0);
    issue(3'd2, 32'd1000, 32'd9);
    repeat (19) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    checks += 4;
    if (bus.hi !== 32'd0) begin errors++; $display("FAIL rstdiv_hi got %h want 0", bus.hi); end
    if (bus.lo !== 32'd0) begin errors++; $display("FAIL rstdiv_lo got %h want 0", bus.lo); end
    if (bus.hilo_busy !== 1'b0) begin errors++; $display("FAIL rstdiv_busy got %0b want 0", bus.hilo_busy); end
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rstdiv_ready got %0b want 1", bus.req_ready); end
    repeat (34) step();
    checks += 1;
    if (bus.lo !== 32'd0) begin errors++; $display("FAIL rstdiv_no_late_commit got %h want 0", bus.lo); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    resetn        = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_src1  = 32'd0;
    bus.req_src2  = 32'd0;
    bus.flush     = 1'b0;
    test_reset();
    test_flush_idle();
    test_multu();
    test_mult();
    test_div_signed();
    test_divu();
    test_div_corner();
    test_mthi_flush();
    test_flush_last_div();
    test_back_to_back();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Owns the HI/LO register pair and schedules every instruction that writes it: mult, multu, div, divu, mthi and mtlo. Sits beside the execute stage. Accepts one operation per handshake, runs multiply in a single internal cycle and divide as a 32-iteration radix-2 restoring sequence, and commits the result to HI/LO. It exports `hilo_busy` so the decode stage stalls mfhi/mflo and any new HI/LO writer until the pending operation completes. It also accepts a flush that aborts in-flight work without touching HI/LO.

## Interface
Parameters:
- `DIV_ITER`, 32: number of divide iterations. Fixed at 32 for the 32-bit datapath.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `req_valid` in 1: the execute stage presents an operation.
- `req_ready` out 1: the block can accept an operation this cycle.
- `req_op` in 3: operation code. 0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo. Codes 6 and 7 are accepted with no effect.
- `req_src1` in 32: rs value (dividend or multiplicand; the mthi/mtlo data).
- `req_src2` in 32: rt value (divisor or multiplier).
- `flush` in 1: abort the current or offered operation.
- `hilo_busy` out 1: a mult/div is in flight; HI/LO are not yet valid.
- `hi` out 32: current HI value.
- `lo` out 32: current LO value.

## Operation
State machine:
- IDLE
  - `req_ready` = 1.
  - An operation is accepted on the edge where `req_valid && req_ready && !flush`.
  - mthi/mtlo: write `req_src1` to HI/LO at the accept edge and stay in IDLE.
  - mult/multu: latch the operands and go to MUL.
  - div/divu with `req_src2 != 0`: latch |src1|, |src2| (signed) or the raw values (unsigned), plus the sign flags. Then go to DIV with `cnt` = 32.
  - div/divu with `req_src2 == 0`: no state change, HI/LO unchanged, busy never asserts.
- MUL (1 cycle)
  - Compute the 64-bit product: signed for mult, unsigned for multu.
  - At the end of the cycle: HI = product[63:32], LO = product[31:0]. Go to IDLE.
- DIV (32 cycles)
  - Each cycle: shift the {rem, quot} pair left by 1, trial-subtract the divisor from the remainder, set the quotient LSB, and decrement `cnt`.
  - On the cycle with `cnt == 1`, commit:
    - LO = quotient, negated if sign(src1) ^ sign(src2) for div.
    - HI = remainder, negated if sign(src1) for div.
    - Go to IDLE.
- `hilo_busy` = (state == MUL || state == DIV).
- `req_ready` = (state == IDLE).
- Arithmetic:
  - Absolute values use 32-bit two's complement, so 0x80000000 stays 0x80000000 when treated as unsigned.
  - div 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- Flush:
  - In MUL/DIV: state goes to IDLE at the next edge and HI/LO are not written, including on the final DIV cycle.
  - In IDLE: an offered request is dropped (no mthi/mtlo write). Flush wins over accept.
- Reset (`resetn` = 0 at an edge): state = IDLE, `cnt` = 0, HI = 0, LO = 0. This holds even mid-operation.

## Timing
- Output values after reset: `req_ready` = 1, `hilo_busy` = 0, `hi` = 0, `lo` = 0.
- `hi`/`lo` are driven directly from registers; there is no bypass.
- Latencies, with the accept edge at the end of cycle T:
  - mthi/mtlo: new value visible in cycle T+1. `hilo_busy` stays 0. `req_ready` stays 1, so back-to-back mthi, mtlo, mult is legal.
  - mult/multu: `hilo_busy` = 1 in cycle T+1. Result visible in T+2, where `req_ready` = 1 again.
  - div/divu: `hilo_busy` = 1 in cycles T+1 through T+32. Result visible in T+33.
- The decode stage must stall mfhi/mflo while `hilo_busy` = 1. When `hilo_busy` falls, `hi`/`lo` already hold the result in that same cycle.
- Flush asserted in cycle C while busy: `hilo_busy` = 0 and `req_ready` = 1 in C+1, and a new request can be accepted in C+1.
- A request offered while `req_ready` = 0 is not consumed. The requester holds `req_valid` and its operands stable.

## Test plan
- **multu:** multu 0xFFFFFFFF × 0xFFFFFFFF. Required: busy for 1 cycle, then HI = 0xFFFFFFFE, LO = 0x00000001 at T+2.
- **mult:** mult 0xFFFFFFFD (−3) × 5. Required: HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- **div, signed:** div −7 / 2. Required: `hilo_busy` high for exactly 32 cycles and `req_ready` low throughout; LO = 0xFFFFFFFD, HI = 0xFFFFFFFF at T+33.
- **divu:** divu 100 / 7. Required: LO = 14, HI = 2.
- **div corner cases:**
  - div 0x80000000 / 0xFFFFFFFF: required LO = 0x80000000, HI = 0.
  - divu x / 0 with prior HI = 0x1234: required HI/LO unchanged and busy never high.
- **mthi + flush mid-div:**
  - mthi 0x55AA, then div 10/3 flushed on its 10th DIV cycle. Required: HI = 0x55AA and LO unchanged, busy drops the next cycle, and a mult 2 × 3 accepted that same cycle yields LO = 6.
- **reset mid-div:** `resetn` = 0 during cycle 20 of a div. Required: HI = LO = 0, `hilo_busy` = 0, `req_ready` = 1 after the edge.
